i3c_tx_byte_unpacker: RTL and testbench
=======================================

Name: i3c_tx_byte_unpacker

Overview:
Upstream data-path stage for the controller flow FSM's write transfers (FetchTxData path). It pops 32-bit dwords from the HCI TX queue and unpacks them little-endian into single bytes. It then drives them, with start/stop flags, onto the I2C controller format-FIFO handshake. The flow FSM supplies a target address byte, a byte count and a stop request, then waits for done_o.

Parameters:
TxFifoWidth, 32, TX queue word width; fixed at 32, 4 byte lanes.
LenWidth, 16, width of byte-count fields (matches descriptor data_length).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start_i  in  1  one-cycle request; sampled only in Idle
byte_len_i  in  LenWidth  number of data bytes to send (0 legal)
addr_byte_i  in  8  address byte {addr[6:0], rnw}
send_addr_i  in  1  emit addr_byte_i before data
stop_after_i  in  1  request STOP after final byte
abort_i  in  1  synchronous abort, returns to Idle
busy_o  out  1  high whenever state != Idle
done_o  out  1  one-cycle pulse when transfer completes
sent_cnt_o  out  LenWidth  data bytes accepted by I2C controller (excludes address)
tx_queue_rvalid_i  in  1  TX queue data valid
tx_queue_rready_o  out  1  TX queue pop
tx_queue_rdata_i  in  TxFifoWidth  TX queue data
fmt_fifo_rvalid_o  out  1  byte valid toward I2C controller
fmt_fifo_rready_i  in  1  I2C controller accepts byte
fmt_byte_o  out  8  byte
fmt_flag_start_before_o  out  1  START before this byte
fmt_flag_stop_after_o  out  1  STOP after this byte

Behaviour:
- Reset: state Idle; all outputs 0; latched len/addr/flags, dword, lane, counter = 0.
- Idle: on start_i, latch byte_len_i, addr_byte_i, send_addr_i and stop_after_i. Clear sent_cnt. Next state is SendAddr if send_addr_i; else Done if len==0; else Fetch.
- SendAddr: fmt_fifo_rvalid_o=1, fmt_byte_o=addr, start_before=1, stop_after=stop_q & (len==0). On rready, go to Done if len==0, else Fetch.
- Fetch: tx_queue_rready_o=1, fmt valid=0. On rvalid, capture rdata into dword, set lane=0, go to Send. No prefetch.
- Send: fmt valid=1, fmt_byte_o=dword[8*lane+:8].
  - start_before=1 only for data byte 0 when !send_addr_q.
  - stop_after = stop_q & (sent_cnt==len-1).
- Send, on rready: sent_cnt++ and lane++ (2-bit, wraps). Then go to Done if sent_cnt+1==len; else Fetch if lane==3; else stay in Send.
- Done: done_o=1 for exactly one cycle, then Idle. sent_cnt_o holds until the next start.
- Partial final dword: unused upper lanes are discarded. The dword is already popped and no extra pop occurs.
- Output timing: all outputs are decoded from registered state; no combinational rready→rvalid path. Valid stays asserted with stable byte and flags until accepted.
- Latency: start_i→first fmt valid = 1 cycle with address, 2 cycles without. Peak throughput is 4 bytes per 5 cycles.
- abort_i (priority over all else): state→Idle on the next edge, no done_o pulse.
  - A byte handshaken in the same cycle as abort counts in sent_cnt.
  - A dword popped in the same cycle as abort is dropped.
- start_i outside Idle: ignored.
- Counter arithmetic is LenWidth-bit. len==2^LenWidth-1 needs no overflow handling beyond the compare.
- Reset mid-transfer: immediate return to reset values; the TX queue is not rewound.

Decomposition:
- Package i3c_ctrl_pkg: enum tx_unpack_state_e {Idle, SendAddr, Fetch, Send, Done}, and a constant TxBytesPerWord=4.
- Single module, no sub-modules. Lane mux and counter stay inline.

Test Plan:
- send_addr=1, addr=0xA0, len=3, stop=1, dword 0x00CCBBAA, rready always 1 → bytes A0(start),AA,BB,CC(stop); 1 pop; done pulse; sent_cnt=3.
- send_addr=0, len=6, dwords 0x44332211,0x88776655 → 11(start),22,33,44,55,66(stop); 2 pops; lanes 2–3 of 2nd dword dropped.
- len=0, send_addr=1, stop=1 → single byte addr with start+stop; 0 pops; done 1 cycle after accept.
- Random rready/rvalid backpressure, len=9, stop=0 → byte and flags stable while valid&!ready; no stop flag; 3 pops; sent_cnt=9.
- abort_i asserted after 2nd data byte accepted, len=8 → Idle next cycle; no done; sent_cnt=2; busy_o=0.
- rst asserted mid-Send → all outputs 0 asynchronously; fresh start then runs a normal transfer.

Source files
------------

// File: rtl/i3c_ctrl_pkg.sv
// Shared types and constants for the I3C controller write data path.
package i3c_ctrl_pkg;

  // Number of byte lanes in one TX queue dword.
  localparam int TxBytesPerWord = 4;

  // Index of the highest byte lane within a dword.
  localparam logic [1:0] TxLastLane = 2'(TxBytesPerWord - 1);

  typedef enum logic [2:0] {
    Idle     = 3'd0,
    SendAddr = 3'd1,
    Fetch    = 3'd2,
    Send     = 3'd3,
    Done     = 3'd4
  } tx_unpack_state_e;

endpackage

// File: rtl/i3c_tx_byte_unpacker.sv
// Pops 32-bit TX queue dwords and emits their bytes little-endian onto the
// format-FIFO handshake. An optional address byte goes first, and START/STOP
// flags are attached to the first and last bytes of the transfer.
module i3c_tx_byte_unpacker
  import i3c_ctrl_pkg::*;
#(
  parameter int TxFifoWidth = 32,
  parameter int LenWidth    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [LenWidth-1:0]    byte_len_i,
  input  logic [7:0]             addr_byte_i,
  input  logic                   send_addr_i,
  input  logic                   stop_after_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [LenWidth-1:0]    sent_cnt_o,
  input  logic                   tx_queue_rvalid_i,
  output logic                   tx_queue_rready_o,
  input  logic [TxFifoWidth-1:0] tx_queue_rdata_i,
  output logic                   fmt_fifo_rvalid_o,
  input  logic                   fmt_fifo_rready_i,
  output logic [7:0]             fmt_byte_o,
  output logic                   fmt_flag_start_before_o,
  output logic                   fmt_flag_stop_after_o
);

  localparam logic [LenWidth-1:0] CntOne = LenWidth'(1);

  tx_unpack_state_e       state_q;
  logic [LenWidth-1:0]    len_q;
  logic [7:0]             addr_q;
  logic                   send_addr_q;
  logic                   stop_q;
  logic [TxFifoWidth-1:0] dword_q;
  logic [1:0]             lane_q;
  logic [LenWidth-1:0]    sent_cnt_q;

  // Count after the byte currently offered is accepted; wraps at LenWidth bits.
  logic [LenWidth-1:0] cnt_nxt;
  assign cnt_nxt = sent_cnt_q + CntOne;

  // Transfer sequencing: latch the request, walk address/fetch/send, honour abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= Idle;
      len_q       <= '0;
      addr_q      <= '0;
      send_addr_q <= 1'b0;
      stop_q      <= 1'b0;
      dword_q     <= '0;
      lane_q      <= '0;
      sent_cnt_q  <= '0;
    end else if (abort_i) begin
      // A byte handed over in the abort cycle still counts; a popped dword is lost.
      state_q <= Idle;
      if (state_q == Send && fmt_fifo_rready_i) begin
        sent_cnt_q <= cnt_nxt;
      end
    end else begin
      case (state_q)
        Idle: begin
          if (start_i) begin
            len_q       <= byte_len_i;
            addr_q      <= addr_byte_i;
            send_addr_q <= send_addr_i;
            stop_q      <= stop_after_i;
            sent_cnt_q  <= '0;
            lane_q      <= '0;
            if (send_addr_i) begin
              state_q <= SendAddr;
            end else if (byte_len_i == '0) begin
              state_q <= Done;
            end else begin
              state_q <= Fetch;
            end
          end
        end
        SendAddr: begin
          if (fmt_fifo_rready_i) begin
            state_q <= (len_q == '0) ? Done : Fetch;
          end
        end
        Fetch: begin
          if (tx_queue_rvalid_i) begin
            dword_q <= tx_queue_rdata_i;
            lane_q  <= '0;
            state_q <= Send;
          end
        end
        Send: begin
          if (fmt_fifo_rready_i) begin
            sent_cnt_q <= cnt_nxt;
            lane_q     <= lane_q + 2'd1;
            if (cnt_nxt == len_q) begin
              state_q <= Done;
            end else if (lane_q == TxLastLane) begin
              state_q <= Fetch;
            end else begin
              state_q <= Send;
            end
          end
        end
        Done: begin
          state_q <= Idle;
        end
        default: begin
          state_q <= Idle;
        end
      endcase
    end
  end

  // Output decode purely from registered state, so no input feeds an output.
  always_comb begin
    busy_o                  = (state_q != Idle);
    done_o                  = (state_q == Done);
    sent_cnt_o              = sent_cnt_q;
    tx_queue_rready_o       = (state_q == Fetch);
    fmt_fifo_rvalid_o       = 1'b0;
    fmt_byte_o              = 8'h00;
    fmt_flag_start_before_o = 1'b0;
    fmt_flag_stop_after_o   = 1'b0;
    case (state_q)
      SendAddr: begin
        fmt_fifo_rvalid_o       = 1'b1;
        fmt_byte_o              = addr_q;
        fmt_flag_start_before_o = 1'b1;
        fmt_flag_stop_after_o   = stop_q && (len_q == '0);
      end
      Send: begin
        fmt_fifo_rvalid_o       = 1'b1;
        fmt_byte_o              = dword_q[{lane_q, 3'b000} +: 8];
        fmt_flag_start_before_o = !send_addr_q && (sent_cnt_q == '0);
        fmt_flag_stop_after_o   = stop_q && (cnt_nxt == len_q);
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_i3c_tx_byte_unpacker.sv
// Directed and randomized checks of the TX byte unpacker against a byte-list model.
module tb_i3c_tx_byte_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] byte_len_i;
  logic [7:0]  addr_byte_i;
  logic        send_addr_i;
  logic        stop_after_i;
  logic        abort_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] sent_cnt_o;
  logic        tx_queue_rvalid_i;
  logic        tx_queue_rready_o;
  logic [31:0] tx_queue_rdata_i;
  logic        fmt_fifo_rvalid_o;
  logic        fmt_fifo_rready_i;
  logic [7:0]  fmt_byte_o;
  logic        fmt_flag_start_before_o;
  logic        fmt_flag_stop_after_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] dq[$];
  logic [9:0]  exp_q[$];

  always #5 clk = ~clk;

  i3c_tx_byte_unpacker #(.TxFifoWidth(32), .LenWidth(16)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .start_i                 (start_i),
    .byte_len_i              (byte_len_i),
    .addr_byte_i             (addr_byte_i),
    .send_addr_i             (send_addr_i),
    .stop_after_i            (stop_after_i),
    .abort_i                 (abort_i),
    .busy_o                  (busy_o),
    .done_o                  (done_o),
    .sent_cnt_o              (sent_cnt_o),
    .tx_queue_rvalid_i       (tx_queue_rvalid_i),
    .tx_queue_rready_o       (tx_queue_rready_o),
    .tx_queue_rdata_i        (tx_queue_rdata_i),
    .fmt_fifo_rvalid_o       (fmt_fifo_rvalid_o),
    .fmt_fifo_rready_i       (fmt_fifo_rready_i),
    .fmt_byte_o              (fmt_byte_o),
    .fmt_flag_start_before_o (fmt_flag_start_before_o),
    .fmt_flag_stop_after_o   (fmt_flag_stop_after_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] fmt_now();
    return {fmt_flag_start_before_o, fmt_flag_stop_after_o, fmt_byte_o};
  endfunction

  // Runs one transfer from a post-edge point; dq must hold the dwords to serve.
  task automatic run_xfer(input bit sa, input logic [7:0] addr, input int len,
                          input bit stp, input bit bp, input int abort_after,
                          input string nm);
    int          pops = 0, dones = 0, data_acc = 0, cyc = 0;
    int          exp_pops;
    bit          hold = 0, expect_done = 0, abort_now = 0, aborted = 0;
    bit          rv, rdy, v;
    logic [9:0]  held;
    logic [31:0] w;
    exp_q.delete();
    if (sa) exp_q.push_back({1'b1, stp && (len == 0), addr});
    for (int i = 0; i < len; i++) begin
      w = dq[i / 4] >> (8 * (i % 4));
      exp_q.push_back({(i == 0) && !sa, stp && (i == len - 1), w[7:0]});
    end
    exp_pops = (len + 3) / 4;

    start_i      = 1'b1;
    byte_len_i   = 16'(len);
    addr_byte_i  = addr;
    send_addr_i  = sa;
    stop_after_i = stp;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk({nm, "_lat1"}, fmt_fifo_rvalid_o, sa);
    chk({nm, "_busy"}, busy_o, 1'b1);

    while (cyc < 400) begin
      if (!busy_o) break;
      if (hold) begin
        chk({nm, "_hold_valid"}, fmt_fifo_rvalid_o, 1'b1);
        chk({nm, "_hold_byte"}, fmt_now(), held);
      end
      rv  = (dq.size() > 0) && (bp ? ($urandom_range(0, 1) == 1) : 1'b1);
      rdy = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (abort_now) begin
        rv = 0; rdy = 0; abort_i = 1'b1;
      end
      tx_queue_rvalid_i = rv;
      tx_queue_rdata_i  = (dq.size() > 0) ? dq[0] : $urandom;
      fmt_fifo_rready_i = rdy;
      v = fmt_fifo_rvalid_o;
      if (expect_done) chk({nm, "_done_after_last"}, done_o, 1'b1);
      expect_done = 0;
      if (done_o) begin
        dones++;
        chk({nm, "_done_q_empty"}, exp_q.size(), 0);
        chk({nm, "_done_cnt"}, sent_cnt_o, len);
      end
      if (v && rdy) begin
        if (exp_q.size() == 0) begin
          chk({nm, "_extra_byte"}, fmt_now(), 10'h3ff);
        end else begin
          if (!(sa && exp_q.size() == len + 1)) data_acc++;
          chk({nm, "_byte"}, fmt_now(), exp_q[0]);
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) expect_done = 1;
        end
      end
      hold = v && !rdy && !abort_now;
      held = fmt_now();
      if (tx_queue_rready_o && rv) begin
        pops++;
        void'(dq.pop_front());
      end
      @(posedge clk); #1;
      abort_i = 1'b0;
      cyc++;
      if (abort_now) begin
        chk({nm, "_abort_busy"}, busy_o, 1'b0);
        chk({nm, "_abort_done"}, done_o, 1'b0);
        chk({nm, "_abort_cnt"}, sent_cnt_o, abort_after);
        aborted = 1;
        break;
      end
      abort_now = (abort_after >= 0) && (data_acc == abort_after);
    end
    tx_queue_rvalid_i = 1'b0;
    fmt_fifo_rready_i = 1'b0;
    if (cyc >= 400) chk({nm, "_timeout"}, 0, 1);
    if (abort_after >= 0) begin
      chk({nm, "_aborted"}, aborted, 1'b1);
      chk({nm, "_no_done"}, dones, 0);
    end else begin
      chk({nm, "_dones"}, dones, 1);
      chk({nm, "_pops"}, pops, exp_pops);
      chk({nm, "_cnt_end"}, sent_cnt_o, len);
      chk({nm, "_left"}, exp_q.size(), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_i = 0; byte_len_i = 0; addr_byte_i = 0; send_addr_i = 0; stop_after_i = 0;
    abort_i = 0; tx_queue_rvalid_i = 0; tx_queue_rdata_i = 0; fmt_fifo_rready_i = 0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_cnt", sent_cnt_o, 0);
    chk("rst_valid", fmt_fifo_rvalid_o, 0);
    chk("rst_fmt", fmt_now(), 0);
    chk("rst_pop", tx_queue_rready_o, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    dq.delete(); dq.push_back(32'h00CCBBAA);
    run_xfer(1, 8'hA0, 3, 1, 0, -1, "addr3");

    dq.delete(); dq.push_back(32'h44332211); dq.push_back(32'h88776655);
    run_xfer(0, 8'h00, 6, 1, 0, -1, "noaddr6");
    chk("noaddr6_dq_used", dq.size(), 0);

    dq.delete();
    run_xfer(1, 8'h5B, 0, 1, 0, -1, "len0");

    dq.delete();
    for (int i = 0; i < 3; i++) dq.push_back($urandom);
    run_xfer(1, 8'h3C, 9, 0, 1, -1, "bp9");

    dq.delete();
    for (int i = 0; i < 2; i++) dq.push_back($urandom);
    run_xfer(0, 8'h00, 8, 1, 1, 2, "abort8");

    // Reset during Send
    dq.delete(); dq.push_back($urandom); dq.push_back($urandom);
    start_i = 1; byte_len_i = 8; send_addr_i = 0; stop_after_i = 1;
    @(posedge clk); #1;
    start_i = 0; tx_queue_rvalid_i = 1; tx_queue_rdata_i = dq[0];
    @(posedge clk); #1;
    tx_queue_rvalid_i = 0;
    chk("rstmid_in_send", fmt_fifo_rvalid_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_busy", busy_o, 0);
    chk("rstmid_valid", fmt_fifo_rvalid_o, 0);
    chk("rstmid_fmt", fmt_now(), 0);
    chk("rstmid_cnt", sent_cnt_o, 0);
    chk("rstmid_pop", tx_queue_rready_o, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    dq.delete();
    for (int i = 0; i < 2; i++) dq.push_back($urandom);
    run_xfer(0, 8'h00, 5, 1, 1, -1, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
